serializador_paralelo: RTL and testbench

Parallel-to-serial loader that sits directly upstream of the 4-stage serial shift register (`registradorNaoBloqueante`). It accepts a parallel word through a Load/Ready handshake and drives it MSB-first, one bit per Clock, onto a serial output. That output wires straight into the shift register's `In`, with `Valid` and `Done` for sequencing. It replaces hand-driven serial stimulus with a reusable, cycle-exact source.

---
 rtl/serializador_paralelo.sv | 104 ++++++++++
 tb/tb_serializador_paralelo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serializador_paralelo.sv
// Parallel-to-serial loader: accepts a word on Load/Ready and shifts it out MSB-first.
// Optional even-parity trailer bit when SERIALIZADOR_PARIDADE_EN is defined.
module serializador_paralelo #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             Load,
    output logic             Ready,
    output logic             Out,
    output logic             Valid,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SERIALIZADOR_PARIDADE_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] cnt;
`ifdef SERIALIZADOR_PARIDADE_EN
    logic             parity;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            shadow <= '0;
            cnt    <= '0;
`ifdef SERIALIZADOR_PARIDADE_EN
            parity <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Load) begin
                        shadow <= Data;
                        cnt    <= '0;
`ifdef SERIALIZADOR_PARIDADE_EN
                        parity <= ^Data;
`endif
                    end
                end
                SHIFT: begin
                    shadow <= {shadow[WIDTH-2:0], 1'b0};
                    // saturate so the counter never wraps past the last bit index
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        Ready      = 1'b0;
        Out        = 1'b0;
        Valid      = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Load) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                Valid = 1'b1;
                Out   = shadow[WIDTH-1];
                if (cnt == LAST) begin
`ifdef SERIALIZADOR_PARIDADE_EN
                    state_next = PARITY;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SERIALIZADOR_PARIDADE_EN
            PARITY: begin
                Valid      = 1'b1;
                Out        = parity;
                state_next = DONE;
            end
`endif
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serializador_paralelo.sv
// Bench for serializador_paralelo: directed table then random cycles against a
// per-cycle expected-output queue model (parity trailer when SERIALIZADOR_PARIDADE_EN).
module tb_serializador_paralelo;

    localparam int W = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] Data;
    logic         Load;
    logic         Ready;
    logic         Out;
    logic         Valid;
    logic         Done;

    serializador_paralelo #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Data  (Data),
        .Load  (Load),
        .Ready (Ready),
        .Out   (Out),
        .Valid (Valid),
        .Done  (Done)
    );

    always #5 Clock = ~Clock;

    // downstream 4-stage register, shifting In->Q0->Q3 while a bit is valid
    logic [3:0] ds_q = '0;
    always @(posedge Clock) begin
        if (Valid) ds_q <= {ds_q[2:0], Out};
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    typedef struct packed {
        logic ready;
        logic out;
        logic valid;
        logic done;
    } exp_t;

    localparam exp_t IDLE_E = '{ready: 1'b1, out: 1'b0, valid: 1'b0, done: 1'b0};

    exp_t         plan[$];
    exp_t         cur;
    logic [W-1:0] last_word;

    // one clock cycle: drive inputs, advance the model at the edge, compare after
    task automatic step(input logic r, input logic l, input logic [W-1:0] d);
        logic was_done;
        Reset = r;
        Load  = l;
        Data  = d;
        @(posedge Clock);
        was_done = 1'b0;
        if (r) begin
            plan.delete();
            cur = IDLE_E;
        end else begin
            if (cur.ready && l) begin
                for (int i = 0; i < W; i++)
                    plan.push_back('{ready: 1'b0, out: d[W-1-i], valid: 1'b1, done: 1'b0});
`ifdef SERIALIZADOR_PARIDADE_EN
                plan.push_back('{ready: 1'b0, out: ^d, valid: 1'b1, done: 1'b0});
`endif
                plan.push_back('{ready: 1'b0, out: 1'b0, valid: 1'b0, done: 1'b1});
                last_word = d;
            end
            was_done = cur.done;
            cur = (plan.size() > 0) ? plan.pop_front() : IDLE_E;
        end
        #1;
        check("ready", 32'(Ready), 32'(cur.ready));
        check("out",   32'(Out),   32'(cur.out));
        check("valid", 32'(Valid), 32'(cur.valid));
        check("done",  32'(Done),  32'(cur.done));
`ifndef SERIALIZADOR_PARIDADE_EN
        if (was_done) check("downstream_q", 32'(ds_q), 32'(last_word));
`endif
    endtask

    // directed table: {reset, load, data}
    localparam int N_DIR = 39;
    logic [5:0] dir_tab [N_DIR] = '{
        6'b11_1111, 6'b11_1111,                                   // reset with load asserted
        6'b01_1011, 6'b00_0000, 6'b00_0000, 6'b00_0000,
        6'b00_0000, 6'b00_0000, 6'b00_0000,                       // single word 1011
        6'b01_1000, 6'b00_0111, 6'b01_0111, 6'b00_0111,
        6'b00_0111, 6'b01_0111, 6'b00_0000,                       // load while busy
        6'b01_1101, 6'b00_0000, 6'b10_0000, 6'b01_0011,
        6'b00_0000, 6'b00_0000, 6'b00_0000, 6'b00_0000,
        6'b00_0000,                                               // reset mid-shift
        6'b01_1001, 6'b01_1001, 6'b01_1001, 6'b01_1001,
        6'b01_1001, 6'b01_1001, 6'b01_0110, 6'b01_0110,
        6'b01_0110, 6'b01_0110, 6'b01_0110, 6'b01_0110,
        6'b00_0000, 6'b00_0000                                    // back-to-back
    };

    initial begin
        logic [5:0] e;
        cur       = IDLE_E;
        last_word = '0;
        Reset     = 1'b1;
        Load      = 1'b0;
        Data      = '0;
        for (int i = 0; i < N_DIR; i++) begin
            e = dir_tab[i];
            step(e[5], e[4], e[3:0]);
        end
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
